// File: rtl/fuzzy_pkg.sv
// Definitions shared by the fuzzy coprocessor actuator stage: run/off states,
// the PWM period length and the slew-limited duty step.
package fuzzy_pkg;

    typedef enum logic {S_OFF = 1'b0, S_RUN = 1'b1} state_e;

    localparam int DUTY_MAX_C = 100;

    // Move cur toward tgt by at most slew (slew==0 means jump straight there).
    // The 9-bit signed difference keeps both directions free of wrap-around.
    function automatic logic [7:0] sat_step(input logic [7:0] cur,
                                            input logic [7:0] tgt,
                                            input logic [7:0] slew);
        logic signed [8:0] diff;
        logic [8:0]        mag;
        logic [8:0]        lim;
        diff = $signed({1'b0, tgt}) - $signed({1'b0, cur});
        mag  = diff[8] ? $unsigned(-diff) : $unsigned(diff);
        lim  = ((slew == 8'd0) || (mag < {1'b0, slew})) ? mag : {1'b0, slew};
        return diff[8] ? (cur - lim[7:0]) : (cur + lim[7:0]);
    endfunction

endpackage

// File: rtl/pwm_timebase.sv
// Prescaler plus phase counter for the PWM; both counters sit at 0 while idle.
module pwm_timebase
    import fuzzy_pkg::*;
#(
    parameter int PRESC_W  = 16,
    parameter int DUTY_MAX = DUTY_MAX_C,
    parameter int PHASE_W  = $clog2(DUTY_MAX)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               run,
    input  logic [PRESC_W-1:0] presc,
    output logic [PHASE_W-1:0] phase,
    output logic               period_tick
);

    localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(DUTY_MAX - 1);

    logic [PRESC_W-1:0] presc_cnt_q, presc_cnt_d;
    logic [PHASE_W-1:0] phase_q, phase_d;
    logic               step;

    always_comb begin
        step        = run && (presc_cnt_q == presc);
        presc_cnt_d = presc_cnt_q;
        phase_d     = phase_q;
        if (!run) begin
            presc_cnt_d = '0;
            phase_d     = '0;
        end else begin
            // >= lets a presc shrunk below the running count wrap cleanly
            presc_cnt_d = (presc_cnt_q >= presc) ? '0 : presc_cnt_q + 1'b1;
            if (step) begin
                phase_d = (phase_q == PHASE_LAST) ? '0 : phase_q + 1'b1;
            end
        end
        period_tick = step && (phase_q == PHASE_LAST);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_cnt_q <= '0;
            phase_q     <= '0;
        end else begin
            presc_cnt_q <= presc_cnt_d;
            phase_q     <= phase_d;
        end
    end

    assign phase = phase_q;

endmodule

// File: rtl/duty_pwm.sv
// Slew-limited PWM actuator: captures the defuzzified output G and applies it
// as a duty cycle, changing duty only at period boundaries.
module duty_pwm
    import fuzzy_pkg::*;
#(
    parameter int PRESC_W  = 16,
    parameter int DUTY_MAX = DUTY_MAX_C
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic [7:0]         g_in,
    input  logic               g_valid,
    input  logic [PRESC_W-1:0] presc,
    input  logic [7:0]         slew_max,
    output logic               pwm_out,
    output logic [7:0]         duty_cur,
    output logic [7:0]         target,
    output logic               period_tick,
    output logic               clamp_flag
);

    localparam int         PHASE_W    = $clog2(DUTY_MAX);
    localparam logic [7:0] DUTY_MAX_B = 8'(DUTY_MAX);

    state_e             state_q, state_d;
    logic [7:0]         duty_cur_q, duty_cur_d;
    logic [7:0]         target_q, target_d;
    logic               clamp_q, clamp_d;
    logic               pwm_q, pwm_d;
    logic               run;
    logic [PHASE_W-1:0] phase;
    logic               tick;

    // Dropping enable stops the timebase in the same cycle, so a tick that
    // coincides with enable falling never reaches the duty register.
    assign run = (state_q == S_RUN) && enable;

    pwm_timebase #(
        .PRESC_W  (PRESC_W),
        .DUTY_MAX (DUTY_MAX),
        .PHASE_W  (PHASE_W)
    ) u_timebase (
        .clk         (clk),
        .rst         (rst),
        .run         (run),
        .presc       (presc),
        .phase       (phase),
        .period_tick (tick)
    );

    always_comb begin
        state_d    = state_q;
        target_d   = target_q;
        clamp_d    = clamp_q;
        duty_cur_d = duty_cur_q;
        case (state_q)
            S_OFF:   if (enable)  state_d = S_RUN;
            S_RUN:   if (!enable) state_d = S_OFF;
            default: state_d = S_OFF;
        endcase
        if (g_valid) begin
            if (g_in > DUTY_MAX_B) begin
                target_d = DUTY_MAX_B;
                clamp_d  = 1'b1;
            end else begin
                target_d = g_in;
            end
        end
        // Uses target_q, so a capture in the tick cycle waits for the next wrap
        if (tick) duty_cur_d = sat_step(duty_cur_q, target_q, slew_max);
        pwm_d = run && (8'(phase) < duty_cur_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_OFF;
            duty_cur_q <= '0;
            target_q   <= '0;
            clamp_q    <= 1'b0;
            pwm_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            duty_cur_q <= duty_cur_d;
            target_q   <= target_d;
            clamp_q    <= clamp_d;
            pwm_q      <= pwm_d;
        end
    end

    assign pwm_out     = pwm_q;
    assign duty_cur    = duty_cur_q;
    assign target      = target_q;
    assign period_tick = tick;
    assign clamp_flag  = clamp_q;

endmodule
